exec_sequencer: RTL and testbench
=================================

EXEC_SEQUENCER -- requirements
Module: exec_sequencer

Interface
REQ-001 Parameter TIMEOUT, default 15, max EXEC cycles waiting for unit done before fault (range 1..255).
REQ-002 Parameter UNIT_MASK, default 16'h003F, bit n=1 means opcode n has an execution unit.
REQ-003 Parameter HALT_OP, default 4'hF, opcode that stops the sequencer.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 run  in  1  level enable; sequencer leaves IDLE only while high.
REQ-007 mem_data  in  16  instruction word at address pc (combinational program memory read).
REQ-008 unit_done  in  16  per-opcode done pulse from execution FSMs.
REQ-009 pc_inc_req  in  1  OR of unit pcInc outputs; operand-fetch PC advance.
REQ-010 pc  out  8  program counter / memory address.
REQ-011 ir  out  16  latched instruction; opcode = ir[15:12].
REQ-012 unit_start  out  16  one-hot start pulse, bit = opcode.
REQ-013 busy  out  1  high in every state except IDLE and HALT.
REQ-014 halted  out  1  high in HALT state.
REQ-015 fault  out  2  00 none, 01 illegal opcode, 10 timeout; sticky.

Function
REQ-016 States IDLE, FETCH, DECODE, EXEC, NEXT, HALT; all outputs registered.
REQ-017 IDLE: run=1 -> FETCH, else stay.
REQ-018 FETCH: ir <= mem_data; -> DECODE (one cycle).
REQ-019 DECODE: opcode==HALT_OP -> HALT, fault unchanged (00).
REQ-020 DECODE: UNIT_MASK[opcode]=0 -> HALT, fault <= 01.
REQ-021 DECODE: otherwise unit_start[opcode] high for exactly the next cycle (first EXEC cycle), wait counter <= 0, -> EXEC.
REQ-022 EXEC: unit_done[opcode]=1 -> NEXT; unit_done bits of other opcodes ignored.
REQ-023 EXEC: each cycle with done low increments wait counter; counter reaching TIMEOUT with done low -> HALT, fault <= 10.
REQ-024 Done on the same cycle the counter reaches TIMEOUT: done wins, no fault.
REQ-025 EXEC: pc_inc_req=1 -> pc <= pc+1 that cycle, at most one increment per cycle, also honoured on the done cycle.
REQ-026 pc_inc_req outside EXEC ignored.
REQ-027 NEXT: pc <= pc+1; run=1 -> FETCH, run=0 -> IDLE.
REQ-028 pc arithmetic mod 256; 8'hFF+1 = 8'h00, no flag.
REQ-029 run deassert during FETCH/DECODE/EXEC does not abort; current instruction completes, stop taken in NEXT.
REQ-030 HALT: sticky until rst; run, unit_done, pc_inc_req ignored; pc holds address of halting instruction.
REQ-031 Instruction latency with 1-cycle unit: FETCH, DECODE, EXEC, NEXT = 4 cycles per instruction.

Reset
REQ-032 rst asserted at any time, including mid-EXEC: state IDLE, pc=0, ir=0, unit_start=0, busy=0, halted=0, fault=00, wait counter=0, immediately and asynchronously.
REQ-033 Unit FSMs not restarted by rst release; sequencer issues no start until a new DECODE.

Verification
REQ-034 run=1, mem[0]=16'h5042, unit_done[5] 2 cycles after start, pc_inc_req once -> unit_start=16'h0020 single pulse, pc ends 2, next FETCH at addr 2.
REQ-035 mem[0]=16'hF000 -> halted=1, fault=00, pc=0, no unit_start pulse.
REQ-036 mem[0]=16'h7000 with default UNIT_MASK -> halted=1, fault=01, unit_start stays 0.
REQ-037 mem[0]=16'h1000, unit_done never -> halted=1, fault=10 after 15 EXEC cycles; done at cycle 15 instead -> no fault, NEXT.
REQ-038 pc preset to 8'hFF via program of 255 one-word instructions -> pc wraps to 8'h00.
REQ-039 rst pulse mid-EXEC, then run=1 -> outputs at reset values, restart fetch from pc=0.

Source files
------------

// File: rtl/exec_sequencer_if.sv
// rtl/exec_sequencer_if.sv - sequencer <-> program memory / execution unit bundle
// The master side (host/bench) drives run, memory read data and unit feedback.
interface exec_sequencer_if;
  logic        run;
  logic [15:0] mem_data;
  logic [15:0] unit_done;
  logic        pc_inc_req;
  logic [7:0]  pc;
  logic [15:0] ir;
  logic [15:0] unit_start;
  logic        busy;
  logic        halted;
  logic [1:0]  fault;

  modport master (
    output run, mem_data, unit_done, pc_inc_req,
    input  pc, ir, unit_start, busy, halted, fault
  );

  modport slave (
    input  run, mem_data, unit_done, pc_inc_req,
    output pc, ir, unit_start, busy, halted, fault
  );
endinterface

// File: rtl/exec_sequencer.sv
// rtl/exec_sequencer.sv - fetch/decode/dispatch sequencer for per-opcode execution units
// Every output comes straight from a flop; next values are formed in one combinational process.
module exec_sequencer #(
  parameter int          TIMEOUT   = 15,
  parameter logic [15:0] UNIT_MASK = 16'h003F,
  parameter logic [3:0]  HALT_OP   = 4'hF
) (
  input logic              clk,
  input logic              rst,
  exec_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_NEXT,
    S_HALT
  } state_t;

  localparam logic [1:0] FAULT_NONE    = 2'b00;
  localparam logic [1:0] FAULT_ILLEGAL = 2'b01;
  localparam logic [1:0] FAULT_TIMEOUT = 2'b10;
  localparam logic [7:0] TIMEOUT_C     = 8'(TIMEOUT);

  state_t      state_q, state_d;
  logic [7:0]  pc_q, pc_d;
  logic [15:0] ir_q, ir_d;
  logic [15:0] start_q, start_d;
  logic        busy_q, busy_d;
  logic        halted_q, halted_d;
  logic [1:0]  fault_q, fault_d;
  logic [7:0]  wait_q, wait_d;
  logic [3:0]  opcode;

  assign opcode = ir_q[15:12];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      pc_q     <= 8'h00;
      ir_q     <= 16'h0000;
      start_q  <= 16'h0000;
      busy_q   <= 1'b0;
      halted_q <= 1'b0;
      fault_q  <= FAULT_NONE;
      wait_q   <= 8'h00;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      start_q  <= start_d;
      busy_q   <= busy_d;
      halted_q <= halted_d;
      fault_q  <= fault_d;
      wait_q   <= wait_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    start_d = 16'h0000;
    fault_d = fault_q;
    wait_d  = wait_q;

    case (state_q)
      S_IDLE: begin
        if (bus.run) state_d = S_FETCH;
      end
      S_FETCH: begin
        ir_d    = bus.mem_data;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        if (opcode == HALT_OP) begin
          state_d = S_HALT;
        end else if (!UNIT_MASK[opcode]) begin
          state_d = S_HALT;
          fault_d = FAULT_ILLEGAL;
        end else begin
          start_d = 16'h0001 << opcode;
          wait_d  = 8'h00;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        // Operand-fetch advance is honoured on every EXEC cycle, including the done cycle.
        if (bus.pc_inc_req) pc_d = pc_q + 8'h01;
        if (bus.unit_done[opcode]) begin
          state_d = S_NEXT;
        end else begin
          wait_d = wait_q + 8'h01;
          if (wait_d == TIMEOUT_C) begin
            state_d = S_HALT;
            fault_d = FAULT_TIMEOUT;
          end
        end
      end
      S_NEXT: begin
        pc_d    = pc_q + 8'h01;
        state_d = bus.run ? S_FETCH : S_IDLE;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d   = (state_d != S_IDLE) && (state_d != S_HALT);
    halted_d = (state_d == S_HALT);
  end

  assign bus.pc         = pc_q;
  assign bus.ir         = ir_q;
  assign bus.unit_start = start_q;
  assign bus.busy       = busy_q;
  assign bus.halted     = halted_q;
  assign bus.fault      = fault_q;

endmodule

// File: tb/tb_exec_sequencer.sv
// tb/tb_exec_sequencer.sv - scoreboard bench for exec_sequencer
// Expected start pulses are queued as programs are loaded and popped as the DUT issues them.
module tb_exec_sequencer;

  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   errors;

  exec_sequencer_if bus();

  exec_sequencer #(
    .TIMEOUT   (15),
    .UNIT_MASK (16'h003F),
    .HALT_OP   (4'hF)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [15:0] mem [256];
  assign bus.mem_data = mem[bus.pc];

  typedef struct {
    logic [15:0] start;
    logic [7:0]  pc;
  } sb_t;
  sb_t sb_q[$];
  int  start_cycs[$];
  int  halt_cyc;

  // unit model controls
  int   done_lat;
  int   inc_at;
  logic inc_always;
  logic noise;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // execution unit model: k counts EXEC cycles since the start pulse
  initial begin
    int          k;
    logic [15:0] op_bits;
    logic        done_now;
    k = 0;
    op_bits = 16'h0;
    bus.unit_done  = 16'h0;
    bus.pc_inc_req = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        k = 0;
        bus.unit_done  = 16'h0;
        bus.pc_inc_req = inc_always;
      end else begin
        if (bus.unit_start != 16'h0) begin
          k = 1;
          op_bits = bus.unit_start;
        end else if (k != 0 && k < 1000) begin
          k++;
        end
        done_now = (k != 0) && (done_lat != 0) && (k == done_lat);
        bus.unit_done = (done_now ? op_bits : 16'h0) | ((noise && k != 0) ? ~op_bits : 16'h0);
        bus.pc_inc_req = inc_always || ((k != 0) && (inc_at != 0) && (k == inc_at));
        if (done_now) k = 0;
      end
    end
  end

  // start-pulse monitor
  initial begin
    logic [15:0] prev_start;
    sb_t         e;
    prev_start = 16'h0;
    forever begin
      @(negedge clk);
      if (!rst && bus.unit_start != 16'h0) begin
        check_val("start_single", 32'(prev_start), 32'h0);
        start_cycs.push_back(cyc);
        if (sb_q.size() == 0) begin
          check_val("start_unexp", 32'(bus.unit_start), 32'h0);
        end else begin
          e = sb_q.pop_front();
          check_val("start_val", 32'(bus.unit_start), 32'(e.start));
          check_val("start_pc", 32'(bus.pc), 32'(e.pc));
        end
      end
      prev_start = rst ? 16'h0 : bus.unit_start;
    end
  end

  task automatic clear_mem(input logic [15:0] fill);
    for (int i = 0; i < 256; i++) mem[i] = fill;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.run = 1'b0;
    done_lat = 1;
    inc_at = 0;
    inc_always = 1'b0;
    noise = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    start_cycs.delete();
    @(negedge clk);
  endtask

  task automatic end_test(input string tag);
    check_val({tag, "_sb_empty"}, 32'(sb_q.size()), 32'h0);
  endtask

  task automatic wait_halted(input string tag, input int budget);
    for (int i = 0; i < budget && !bus.halted; i++) @(negedge clk);
    halt_cyc = cyc;
    check_val({tag, "_halted"}, 32'(bus.halted), 32'h1);
  endtask

  task automatic push_start(input logic [3:0] op, input logic [7:0] pc);
    sb_t e;
    e.start = 16'h0001 << op;
    e.pc = pc;
    sb_q.push_back(e);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.run = 1'b0;
    done_lat = 1;
    inc_at = 0;
    inc_always = 1'b0;
    noise = 1'b0;
    clear_mem(16'hF000);

    // reset state
    do_reset();
    check_val("rst_pc", 32'(bus.pc), 32'h0);
    check_val("rst_ir", 32'(bus.ir), 32'h0);
    check_val("rst_start", 32'(bus.unit_start), 32'h0);
    check_val("rst_busy", 32'(bus.busy), 32'h0);
    check_val("rst_halted", 32'(bus.halted), 32'h0);
    check_val("rst_fault", 32'(bus.fault), 32'h0);

    // opcode 5, done two cycles after start, one operand-fetch advance
    clear_mem(16'hF000);
    mem[0] = 16'h5042;
    do_reset();
    done_lat = 3;
    inc_at = 2;
    push_start(4'h5, 8'h00);
    bus.run = 1'b1;
    wait_halted("op5", 100);
    check_val("op5_pc", 32'(bus.pc), 32'h2);
    check_val("op5_ir", 32'(bus.ir), 32'hF000);
    check_val("op5_fault", 32'(bus.fault), 32'h0);
    end_test("op5");

    // 4-cycle latency with 1-cycle unit
    clear_mem(16'hF000);
    mem[0] = 16'h3000;
    mem[1] = 16'h3000;
    do_reset();
    push_start(4'h3, 8'h00);
    push_start(4'h3, 8'h01);
    bus.run = 1'b1;
    wait_halted("lat", 100);
    check_val("lat_n", 32'(start_cycs.size()), 32'h2);
    if (start_cycs.size() == 2)
      check_val("lat_delta", 32'(start_cycs[1] - start_cycs[0]), 32'h4);
    check_val("lat_pc", 32'(bus.pc), 32'h2);
    end_test("lat");

    // halt opcode; pc_inc_req held high must not move pc
    clear_mem(16'hF000);
    do_reset();
    inc_always = 1'b1;
    bus.run = 1'b1;
    wait_halted("halt", 50);
    check_val("halt_fault", 32'(bus.fault), 32'h0);
    check_val("halt_busy", 32'(bus.busy), 32'h0);
    for (int i = 0; i < 6; i++) begin
      bus.run = i[0];
      @(negedge clk);
    end
    check_val("halt_pc", 32'(bus.pc), 32'h0);
    check_val("halt_sticky", 32'(bus.halted), 32'h1);
    end_test("halt");

    // illegal opcode
    clear_mem(16'hF000);
    mem[0] = 16'h7000;
    do_reset();
    bus.run = 1'b1;
    wait_halted("ill", 50);
    check_val("ill_fault", 32'(bus.fault), 32'h1);
    check_val("ill_pc", 32'(bus.pc), 32'h0);
    end_test("ill");

    // timeout, with other units' done bits asserted as noise
    clear_mem(16'hF000);
    mem[0] = 16'h1000;
    do_reset();
    done_lat = 0;
    noise = 1'b1;
    push_start(4'h1, 8'h00);
    bus.run = 1'b1;
    wait_halted("tmo", 100);
    check_val("tmo_fault", 32'(bus.fault), 32'h2);
    if (start_cycs.size() == 1)
      check_val("tmo_cycles", 32'(halt_cyc - start_cycs[0]), 32'd15);
    end_test("tmo");

    // done on the 15th EXEC cycle wins
    clear_mem(16'hF000);
    mem[0] = 16'h1000;
    do_reset();
    done_lat = 15;
    push_start(4'h1, 8'h00);
    bus.run = 1'b1;
    wait_halted("edge", 100);
    check_val("edge_fault", 32'(bus.fault), 32'h0);
    check_val("edge_pc", 32'(bus.pc), 32'h1);
    end_test("edge");

    // pc wrap, stop requested via run=0 while in flight
    clear_mem(16'h0000);
    do_reset();
    for (int i = 0; i < 256; i++) push_start(4'h0, 8'(i));
    bus.run = 1'b1;
    for (int i = 0; i < 1200 && bus.pc != 8'hFF; i++) @(negedge clk);
    check_val("wrap_ff", 32'(bus.pc), 32'hFF);
    bus.run = 1'b0;
    for (int i = 0; i < 50 && bus.busy; i++) @(negedge clk);
    check_val("wrap_idle", 32'(bus.busy), 32'h0);
    check_val("wrap_pc", 32'(bus.pc), 32'h0);
    check_val("wrap_halted", 32'(bus.halted), 32'h0);
    end_test("wrap");

    // async reset mid-EXEC, then restart from pc 0
    clear_mem(16'hF000);
    mem[0] = 16'h1000;
    do_reset();
    done_lat = 0;
    inc_at = 1;
    push_start(4'h1, 8'h00);
    bus.run = 1'b1;
    for (int i = 0; i < 20 && start_cycs.size() == 0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    check_val("mid_busy", 32'(bus.busy), 32'h1);
    #2 rst = 1'b1;
    #1;
    check_val("mid_rst_pc", 32'(bus.pc), 32'h0);
    check_val("mid_rst_ir", 32'(bus.ir), 32'h0);
    check_val("mid_rst_busy", 32'(bus.busy), 32'h0);
    check_val("mid_rst_fault", 32'(bus.fault), 32'h0);
    check_val("mid_rst_start", 32'(bus.unit_start), 32'h0);
    mem[0] = 16'h2000;
    mem[1] = 16'hF000;
    done_lat = 1;
    inc_at = 0;
    push_start(4'h2, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    wait_halted("mid", 100);
    check_val("mid_pc", 32'(bus.pc), 32'h1);
    check_val("mid_fault", 32'(bus.fault), 32'h0);
    end_test("mid");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
